// File: rtl/clock_pkg.sv
// clock_pkg: shared state, selection codes and field limits for the clock front panel
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOUR,
        ST_MIN,
        ST_SEC
    } state_t;

    localparam logic [1:0] SEL_RUN  = 2'b00;
    localparam logic [1:0] SEL_MIN  = 2'b01;
    localparam logic [1:0] SEL_HOUR = 2'b10;
    localparam logic [1:0] SEL_SEC  = 2'b11;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    function automatic state_t next_field(input state_t s);
        return (s == ST_RUN) ? ST_HOUR : (s == ST_HOUR) ? ST_MIN : (s == ST_MIN) ? ST_SEC : ST_RUN;
    endfunction

    function automatic logic [1:0] sel_of(input state_t s);
        return (s == ST_HOUR) ? SEL_HOUR : (s == ST_MIN) ? SEL_MIN : (s == ST_SEC) ? SEL_SEC : SEL_RUN;
    endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// time_set_controller_if: button inputs and time-set outputs between panel and clock core
interface time_set_controller_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [7:0] value_set_register;
    logic [1:0] value_set_selection;
    logic       setting_active;
    logic       blink;

    modport master (
        output btn_mode, btn_inc, btn_dec,
        input  value_set_register, value_set_selection, setting_active, blink
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec,
        output value_set_register, value_set_selection, setting_active, blink
    );
endinterface

// File: rtl/time_set_controller_button_debounce.sv
// button_debounce: synchronise, debounce and pulse one raw button, with optional auto-repeat
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic [1:0]  r_sync;
    logic [31:0] r_cnt;
    logic [31:0] r_rep;
    logic        r_level;
    logic        r_level_q;
    logic        w_rise;
    logic        w_rep_hit;

    assign w_rise    = r_level & ~r_level_q;
    assign w_rep_hit = REPEAT_EN && r_level && (r_rep == REPEAT_DELAY);
    assign o_pulse   = w_rise | w_rep_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_rep     <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_level_q <= r_level;
            // counter only advances while the synchronised level disagrees, so any bounce back restarts it
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DEBOUNCE_CYCLES - 1) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1;
            end
            // after the first repeat, rewind so the next hit lands REPEAT_RATE cycles later
            r_rep <= !r_level ? '0 : w_rep_hit ? REPEAT_DELAY - REPEAT_RATE + 1 : r_rep + 1;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: button-driven hour/minute/second editor feeding the clock core set interface
module time_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000,
    parameter int unsigned BLINK_CYCLES    = 12500000
) (
    input logic                  clk,
    input logic                  rst,
    time_set_controller_if.slave bus
);

    logic        w_mode;
    logic        w_inc;
    logic        w_dec;
    logic        w_edit;
    logic [7:0]  w_max;
    state_t      r_state;
    state_t      w_state_nx;
    logic [7:0]  r_value;
    logic [7:0]  w_value_nx;
    logic [1:0]  r_sel;
    logic        r_active;
    logic [31:0] r_bcnt;
    logic [31:0] w_bcnt_nx;
    logic        r_blink;
    logic        w_blink_nx;
    logic        w_blink_clr;

    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max, input logic up);
        if (up)
            return (v == max) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
        return (v == 8'h00) ? max : (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0)
    ) u_mode (.clk(clk), .rst(rst), .i_btn(bus.btn_mode), .o_pulse(w_mode));

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
    ) u_inc (.clk(clk), .rst(rst), .i_btn(bus.btn_inc), .o_pulse(w_inc));

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
    ) u_dec (.clk(clk), .rst(rst), .i_btn(bus.btn_dec), .o_pulse(w_dec));

    always_comb begin
        w_state_nx  = r_state;
        w_value_nx  = r_value;
        w_max       = (r_state == ST_HOUR) ? HOUR_MAX : MINSEC_MAX;
        w_edit      = (r_state != ST_RUN) && !w_mode && (w_inc ^ w_dec);
        if (w_mode) begin
            w_state_nx = next_field(r_state);
            w_value_nx = 8'h00;
        end else if (w_edit) begin
            w_value_nx = bcd_step(r_value, w_max, w_inc);
        end
        // a field change restarts the blink phase; RUN holds it off entirely
        w_blink_clr = w_mode || (w_state_nx == ST_RUN);
        w_bcnt_nx   = (w_blink_clr || r_bcnt == BLINK_CYCLES - 1) ? '0 : r_bcnt + 1;
        w_blink_nx  = w_blink_clr ? 1'b0 : (r_bcnt == BLINK_CYCLES - 1) ? ~r_blink : r_blink;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_value  <= 8'h00;
            r_sel    <= SEL_RUN;
            r_active <= 1'b0;
            r_bcnt   <= '0;
            r_blink  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_value  <= w_value_nx;
            r_sel    <= sel_of(w_state_nx);
            r_active <= (w_state_nx != ST_RUN);
            r_bcnt   <= w_bcnt_nx;
            r_blink  <= w_blink_nx;
        end
    end

    assign bus.value_set_register  = r_value;
    assign bus.value_set_selection = r_sel;
    assign bus.setting_active      = r_active;
    assign bus.blink               = r_blink;

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
Front-panel setter for the digital clock. It debounces three push buttons and runs a field-select state machine: hours, then minutes, then seconds, then back to run. It drives the clock core's time-set interface (value_set_register, value_set_selection) with range-limited two-digit BCD values. It sits between the board buttons and the clock core's set inputs.

Parameters:
DEBOUNCE_CYCLES, 50000, clk cycles a raw button level must stay stable before it is accepted
REPEAT_DELAY, 25000000, clk cycles inc/dec must be held before auto-repeat starts
REPEAT_RATE, 5000000, clk cycles between auto-repeat steps
BLINK_CYCLES, 12500000, clk cycles per half-period of the blink output

Ports:
clk  input  1  system clock, the single clock domain
rst  input  1  synchronous, active-high reset
btn_mode  input  1  raw asynchronous button, active-high; advances the field
btn_inc  input  1  raw asynchronous button, active-high; increments the current field
btn_dec  input  1  raw asynchronous button, active-high; decrements the current field
value_set_register  output  8  BCD value, [7:4] tens, [3:0] units
value_set_selection  output  2  00 run, 01 minutes, 10 hours, 11 seconds
setting_active  output  1  high in any SET state
blink  output  1  square wave while setting; constant 0 in RUN

Behaviour:
- Reset: rst is sampled on posedge clk only. Reset state:
  - FSM in RUN.
  - All outputs 0.
  - Synchronisers, debounced levels, repeat counters and blink counter all 0.
- Input conditioning (per button):
  - 2-FF synchroniser.
  - Debounce counter restarts on any change of the synchronised level.
  - The debounced level updates only after DEBOUNCE_CYCLES stable cycles.
  - A 0->1 transition of the debounced level produces a 1-cycle press pulse.
- Auto-repeat (inc and dec only):
  - While the debounced level stays high, a repeat counter runs.
  - An extra pulse is issued at REPEAT_DELAY, then every REPEAT_RATE cycles.
  - The counter clears when the debounced level drops.
- FSM states and selection output:
  - RUN: selection 00.
  - SET_HOUR: selection 10.
  - SET_MIN: selection 01.
  - SET_SEC: selection 11.
- Transitions, each on a mode pulse: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN. No other transitions.
- Entering any SET state loads the edit value with 8'h00.
- Outputs are registered. value_set_register and value_set_selection change the cycle after the causing pulse (latency 1).
  - In RUN, value_set_register is 8'h00.
  - In SET states, value_set_register is held continuously so the clock core keeps loading it on every 1 Hz edge.
- BCD arithmetic:
  - Units 0-9 carry into tens.
  - Hour range 00-23: inc 23->00, inc 09->10, inc 19->20; dec 00->23, dec 10->09.
  - Minute and second range 00-59: inc 59->00; dec 00->59.
  - Output digits are never outside the legal range.
- Simultaneous events:
  - mode pulse together with inc/dec pulse: mode wins, inc/dec dropped.
  - inc and dec pulse in the same cycle: both ignored.
  - inc/dec in RUN: ignored.
- blink:
  - Toggles every BLINK_CYCLES while setting_active.
  - Forced to 0 and its counter cleared in RUN.
  - Counter restarts on every field change.
- Reset mid-setting: returns to RUN with selection 00 the cycle after rst is sampled high. No partial value is retained.

Decomposition:
- Shared package clock_pkg:
  - FSM state enum.
  - Selection codes SEL_RUN=2'b00, SEL_MIN=2'b01, SEL_HOUR=2'b10, SEL_SEC=2'b11.
  - Field limits HOUR_MAX=8'h23, MINSEC_MAX=8'h59.
- One sub-module, button_debounce (synchroniser, debounce counter, press pulse, optional auto-repeat enable), instantiated three times with repeat enabled on inc and dec only.
- BCD inc/dec logic is a function inside time_set_controller.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, BLINK_CYCLES=8.
1. Reset, then idle 50 cycles -> selection 00, value 8'h00, setting_active 0, blink 0.
2. Mode press held 10 cycles -> SET_HOUR (selection 10, value 00). Press inc 10 times -> value 8'h10. Then four more presses -> 8'h14.
3. In SET_HOUR at 8'h23: inc -> 8'h00; dec -> 8'h23. In SET_MIN at 8'h00: dec -> 8'h59; inc -> 8'h00.
4. Mode glitch toggling every cycle for 3 cycles, then release -> no state change. Clean mode press 3 times from RUN -> selections 10, 01, 11 in order; 4th press -> 00.
5. In SET_SEC, hold inc 40 cycles after debounce -> pulses at press and at +20, +25, +30, +35 -> value 8'h05. inc and dec asserted together -> value unchanged.
6. rst asserted while in SET_MIN with value 8'h37 -> next cycle selection 00, value 00, blink 0. Mode plus inc pulses in the same cycle -> state advances, value 00.
